// File: rtl/ph_pkg.sv
// rtl/ph_pkg.sv - shared PH cache definitions
//
// Purpose: values shared by the PH cache fill and read sides: the reader
// state encoding, the packet header tag and the default frame length.
package ph_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_STREAM = 2'd2
   } ph_state_e;

   localparam logic [7:0] PH_HDR_TAG     = 8'hA5;
   localparam int         PH_NUM_ENTRIES = 128;

endpackage

// File: rtl/ph_sync_fifo.sv
// rtl/ph_sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose: small synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push_i, wdata_i write request and data
//   pop_i           read request; rdata_o shows the head entry
//   count_o         current occupancy (0..DEPTH)
//   full_o, empty_o occupancy flags
module ph_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Requests that would corrupt state are ignored rather than trusted.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ph_cache_reader.sv
// rtl/ph_cache_reader.sv - drains one PH frame from the cache as a stream packet
//
// Purpose: on the falling edge of ph_cache_valid, reads NUM_ENTRIES 16-bit
// samples from the cache read port and sends them as one packet: a header
// beat {HDR_TAG, 8'h00, frame_cnt} followed by words {odd, even}.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   ph_cache_valid              cache fill in progress; falling edge = frame ready
//   ph_cache_enb/raddr/data     cache read port, data one cycle after enb
//   m_axis_tdata/tvalid/tlast/tready  packet stream
//   busy                        packet in progress
//   frame_cnt                   packets fully sent (wraps)
//   drop_cnt                    triggers ignored while busy (saturates)
module ph_cache_reader
   import ph_pkg::*;
#(
   parameter int         NUM_ENTRIES = PH_NUM_ENTRIES,
   parameter logic [7:0] HDR_TAG     = PH_HDR_TAG,
   parameter int         FIFO_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ph_cache_valid,
   output logic        ph_cache_enb,
   output logic [7:0]  ph_cache_raddr,
   input  logic [15:0] ph_cache_data,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   localparam logic [7:0] LAST_ADDR = 8'(NUM_ENTRIES - 1);
   localparam logic [7:0] LAST_WORD = 8'(NUM_ENTRIES / 2 - 1);
   localparam int         CW        = $clog2(FIFO_DEPTH) + 1;

   ph_state_e   state_q, state_d;
   logic        vld_q;
   logic [7:0]  addr_q, addr_d;
   logic        done_q, done_d;
   logic        open_q, open_d;
   logic        rd_vld_q;
   logic        rd_odd_q;
   logic [15:0] low_q;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [15:0] frame_cnt_q;
   logic [15:0] drop_cnt_q;

   logic          trigger;
   logic          active;
   logic          credit_ok;
   logic          rd_issue;
   logic          fifo_push;
   logic          fifo_pop;
   logic [31:0]   fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   assign trigger = vld_q & ~ph_cache_valid;
   assign active  = (state_q != ST_IDLE);

   // A pair of reads reserves one FIFO slot when its even read is issued;
   // open_q marks that reservation until the completed word is pushed.
   // Odd reads ride on the reservation already taken, so only even reads
   // wait for credit. This is what keeps in-flight data from ever finding
   // the FIFO full.
   assign credit_ok = ~fifo_full & ((int'(fifo_count) + int'(open_q)) < FIFO_DEPTH);
   assign rd_issue  = active & ~done_q & (addr_q[0] | credit_ok);

   assign fifo_push = rd_vld_q & rd_odd_q;
   assign fifo_pop  = (state_q == ST_STREAM) & m_axis_tready & ~fifo_empty;

   ph_sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (fifo_push),
      .wdata_i ({ph_cache_data, low_q}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      done_d        = done_q;
      open_d        = open_q;
      wcnt_d        = wcnt_q;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;

      // Read engine; raddr holds on the last address once it is issued.
      if (fifo_push) begin
         open_d = 1'b0;
      end
      if (rd_issue) begin
         if (!addr_q[0]) begin
            open_d = 1'b1;
         end
         if (addr_q == LAST_ADDR) begin
            done_d = 1'b1;
         end else begin
            addr_d = addr_q + 8'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               state_d = ST_HEADER;
               addr_d  = '0;
               done_d  = 1'b0;
               open_d  = 1'b0;
               wcnt_d  = '0;
            end
         end
         ST_HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {HDR_TAG, 8'h00, frame_cnt_q};
            if (m_axis_tready) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            m_axis_tvalid = ~fifo_empty;
            m_axis_tdata  = fifo_rdata;
            m_axis_tlast  = ~fifo_empty & (wcnt_q == LAST_WORD);
            if (fifo_pop) begin
               wcnt_d = wcnt_q + 8'd1;
               if (m_axis_tlast) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         vld_q       <= 1'b0;
         addr_q      <= '0;
         done_q      <= 1'b0;
         open_q      <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_odd_q    <= 1'b0;
         low_q       <= '0;
         wcnt_q      <= '0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q  <= state_d;
         vld_q    <= ph_cache_valid;
         addr_q   <= addr_d;
         done_q   <= done_d;
         open_q   <= open_d;
         rd_vld_q <= rd_issue;
         rd_odd_q <= addr_q[0];
         wcnt_q   <= wcnt_d;
         if (rd_vld_q && !rd_odd_q) begin
            low_q <= ph_cache_data;
         end
         if (fifo_pop && m_axis_tlast) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         // The tlast cycle is still busy, so a trigger there is dropped too.
         if (trigger && active && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign ph_cache_enb   = rd_issue;
   assign ph_cache_raddr = addr_q;
   assign busy           = active;
   assign frame_cnt      = frame_cnt_q;
   assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_ph_cache_reader.sv
// tb/tb_ph_cache_reader.sv - scoreboard bench for ph_cache_reader
module tb_ph_cache_reader;

   localparam int NE = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic        ph_cache_valid;
   logic        ph_cache_enb;
   logic [7:0]  ph_cache_raddr;
   logic [15:0] ph_cache_data = 16'h0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        busy;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   logic        valid2;
   logic        enb2;
   logic [7:0]  raddr2;
   logic [15:0] data2 = 16'h0;
   logic [31:0] tdata2;
   logic        tvalid2;
   logic        tlast2;
   logic        tready2;
   logic        busy2;
   logic [15:0] frame_cnt2;
   logic [15:0] drop_cnt2;

   int n_vec = 0;
   int n_err = 0;

   logic [32:0] exp_q[$];
   logic [32:0] exp2_q[$];
   int          beats = 0;
   int          beats2 = 0;
   int          rd_issued = 0;
   int          ovf = 0;
   int          unf = 0;
   int          rdy_mode = 0;
   logic        stall_q = 1'b0;
   logic [32:0] stall_val = '0;

   always #5 clk = ~clk;

   ph_cache_reader #(.NUM_ENTRIES(NE)) dut (
      .clk            (clk),
      .rst            (rst),
      .ph_cache_valid (ph_cache_valid),
      .ph_cache_enb   (ph_cache_enb),
      .ph_cache_raddr (ph_cache_raddr),
      .ph_cache_data  (ph_cache_data),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tready  (m_axis_tready),
      .busy           (busy),
      .frame_cnt      (frame_cnt),
      .drop_cnt       (drop_cnt)
   );

   ph_cache_reader #(.NUM_ENTRIES(2)) dut2 (
      .clk            (clk),
      .rst            (rst),
      .ph_cache_valid (valid2),
      .ph_cache_enb   (enb2),
      .ph_cache_raddr (raddr2),
      .ph_cache_data  (data2),
      .m_axis_tdata   (tdata2),
      .m_axis_tvalid  (tvalid2),
      .m_axis_tlast   (tlast2),
      .m_axis_tready  (tready2),
      .busy           (busy2),
      .frame_cnt      (frame_cnt2),
      .drop_cnt       (drop_cnt2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cache model: address k holds 16'h1000+k, one cycle read latency.
   always @(posedge clk) begin
      if (ph_cache_enb) begin
         ph_cache_data <= 16'h1000 + {8'h00, ph_cache_raddr};
         rd_issued     <= rd_issued + 1;
      end
      if (enb2) begin
         data2 <= 16'h1000 + {8'h00, raddr2};
      end
   end

   always @(negedge clk) begin
      logic [32:0] e;
      if (!rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q && !m_axis_tvalid) check("tvalid_drop", 0, 1);
         if (stall_q && m_axis_tvalid) check("stall_stable", {m_axis_tlast, m_axis_tdata}, stall_val);
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", {m_axis_tlast, m_axis_tdata}, 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("beat", {m_axis_tlast, m_axis_tdata}, e);
            end
            beats++;
            stall_q = 1'b0;
         end else if (m_axis_tvalid) begin
            stall_q   = 1'b1;
            stall_val = {m_axis_tlast, m_axis_tdata};
         end else begin
            stall_q = 1'b0;
         end
         if (tvalid2 && tready2) begin
            if (exp2_q.size() == 0) begin
               check("extra_beat2", {tlast2, tdata2}, 64'hDEAD);
            end else begin
               e = exp2_q.pop_front();
               check("beat2", {tlast2, tdata2}, e);
            end
            beats2++;
         end
         if (dut.u_fifo.push_i && dut.u_fifo.full_o && !dut.u_fifo.pop_i) ovf++;
         if (dut.u_fifo.pop_i && dut.u_fifo.empty_o) unf++;
      end
   end

   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 99) < 30);
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int hi);
      ph_cache_valid = 1'b1;
      tick(hi);
      ph_cache_valid = 1'b0;
   endtask

   task automatic expect_packet(input logic [15:0] fc);
      logic [15:0] lo;
      exp_q.push_back({1'b0, 8'hA5, 8'h00, fc});
      for (int i = 0; i < NE / 2; i++) begin
         lo = 16'h1000 + 16'(2 * i);
         exp_q.push_back({(i == NE / 2 - 1), lo + 16'd1, lo});
      end
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         tick(1);
         n++;
      end
      check({tag, "_timeout"}, (n < budget), 1);
   endtask

   initial begin
      int base;
      int n;
      rst            = 1'b0;
      ph_cache_valid = 1'b0;
      valid2         = 1'b0;
      tready2        = 1'b1;
      tick(3);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_enb", ph_cache_enb, 0);
      check("rst_raddr", ph_cache_raddr, 0);
      check("rst_busy", busy, 0);
      check("rst_frame", frame_cnt, 0);
      check("rst_drop", drop_cnt, 0);
      rst = 1'b1;
      tick(2);

      // Full packet, tready held high.
      expect_packet(16'd0);
      pulse(10);
      wait_done(2000, "pkt_a");
      check("a_frame", frame_cnt, 1);
      check("a_busy", busy, 0);

      // Random backpressure.
      rdy_mode = 1;
      expect_packet(16'd1);
      pulse(10);
      wait_done(6000, "pkt_b");
      check("b_frame", frame_cnt, 2);
      rdy_mode = 0;
      tick(2);

      // Second trigger while busy is dropped; later trigger is accepted.
      expect_packet(16'd2);
      pulse(10);
      tick(10);
      pulse(10);
      wait_done(2000, "pkt_c");
      check("c_drop", drop_cnt, 1);
      check("c_frame", frame_cnt, 3);
      expect_packet(16'd3);
      pulse(10);
      wait_done(2000, "pkt_c2");
      check("c2_frame", frame_cnt, 4);

      // Reset mid-packet.
      expect_packet(16'd4);
      pulse(10);
      base = beats;
      n = 0;
      while (beats < base + 30 && n < 2000) begin
         tick(1);
         n++;
      end
      check("d_reach_timeout", (n < 2000), 1);
      rst = 1'b0;
      #1;
      check("d_tvalid", m_axis_tvalid, 0);
      check("d_frame", frame_cnt, 0);
      check("d_drop", drop_cnt, 0);
      check("d_busy", busy, 0);
      check("d_enb", ph_cache_enb, 0);
      exp_q.delete();
      tick(2);
      rst = 1'b1;
      tick(2);
      expect_packet(16'd0);
      pulse(10);
      wait_done(2000, "pkt_d");
      check("d2_frame", frame_cnt, 1);

      // Long stall after trigger: header held, reads limited by credit.
      rdy_mode = 2;
      tick(2);
      base = rd_issued;
      expect_packet(16'd1);
      pulse(10);
      tick(200);
      check("e_tvalid", m_axis_tvalid, 1);
      check("e_hdr", m_axis_tdata, 32'hA5000001);
      check("e_reads_le4", ((rd_issued - base) <= 4), 1);
      rdy_mode = 0;
      wait_done(2000, "pkt_e");
      check("e_frame", frame_cnt, 2);

      // Two-entry build.
      exp2_q.push_back({1'b0, 32'hA5000000});
      exp2_q.push_back({1'b1, 32'h10011000});
      valid2 = 1'b1;
      tick(10);
      valid2 = 1'b0;
      n = 0;
      while ((exp2_q.size() != 0 || busy2) && n < 200) begin
         tick(1);
         n++;
      end
      check("f_timeout", (n < 200), 1);
      check("f_beats", beats2, 2);
      check("f_frame", frame_cnt2, 1);

      tick(5);
      check("fifo_overflow", ovf, 0);
      check("fifo_underflow", unf, 0);
      check("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ph_cache_reader.md
Name: ph_cache_reader

Overview:
- Read side of the PH ping-pong cache: drains one completed PH frame from the cache read port and emits it as a 32-bit AXI-Stream packet.
- Sits between the PH cache and the downstream PH packet/UDP path.
- Each packet has one header beat followed by packed 16-bit PH samples.
- Applies AXI backpressure without losing samples, despite the 1-cycle BRAM read latency.

Parameters:
- NUM_ENTRIES, 128: samples per frame; even, 2..256.
- HDR_TAG, 8'hA5: tag placed in header bits [31:24].
- FIFO_DEPTH, 2: packed-word output buffer depth; power of 2, ≥2.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- ph_cache_valid  in  1  high while the cache is being filled with a frame; its falling edge means the frame is complete.
- ph_cache_enb  out  1  cache read-port enable.
- ph_cache_raddr  out  8  cache read address.
- ph_cache_data  in  16  cache read data, valid 1 cycle after enb/raddr.
- m_axis_tdata  out  32  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  last beat of the packet.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high from trigger until the tlast handshake.
- frame_cnt  out  16  count of packets fully sent; wraps.
- drop_cnt  out  16  count of triggers ignored while busy; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, async):
  - state IDLE; all outputs 0, including tvalid, tlast, enb, raddr, busy and both counters.
  - FIFO emptied; edge-detect register cleared.
  - Deassertion mid-packet abandons the packet; no partial beats follow.
- Trigger:
  - vld_d is ph_cache_valid registered; trigger = vld_d & ~ph_cache_valid.
  - Trigger in IDLE: HEADER next cycle; busy=1 from that cycle.
  - Trigger when not IDLE: ignored, drop_cnt++ (saturating).
- State HEADER:
  - tvalid=1, tdata = {HDR_TAG, 8'h00, frame_cnt}, tlast=0.
  - Move to STREAM on handshake (tvalid & tready).
  - Cache reads already begin in this state.
- Read engine, active in HEADER and STREAM:
  - Issues raddr 0..NUM_ENTRIES-1 in order, at most one read per cycle.
  - Reads are gated by credit: issue only if FIFO occupancy + pairs in flight or half-assembled < FIFO_DEPTH.
  - Returned data: even address goes to the low half-register; odd address completes the word {odd, even}, which is pushed to the FIFO.
  - enb=0 after the last address is issued; raddr holds.
- State STREAM:
  - tvalid = FIFO not empty; tdata = FIFO head.
  - tlast=1 on word NUM_ENTRIES/2-1 only.
  - Pop on handshake. tdata/tlast stay stable while tvalid & ~tready.
- tlast handshake:
  - frame_cnt++ (wraps 16'hFFFF→0); back to IDLE; busy=0 the same cycle state reaches IDLE.
  - A trigger in that same cycle counts as busy and is dropped.
- Throughput: with tready held 1, one data beat every 2 cycles (read-port bound).
  - Packet = 1 + NUM_ENTRIES/2 beats.
  - First data beat no later than 3 cycles after the header handshake.
- Backpressure: a tready=0 stall of any length loses and duplicates nothing. The read engine stalls on credit; in-flight BRAM data always has FIFO space by construction.
- tready high while tvalid low: no effect.
- The FIFO never overflows and never underflows. The bench asserts both.

Decomposition:
- Shared package ph_pkg:
  - state encoding (IDLE, HEADER, STREAM);
  - PH_HDR_TAG constant;
  - PH_NUM_ENTRIES default, shared with the cache fill side.
- One natural sub-module: ph_sync_fifo (parameterised width/depth, push/pop, count, full/empty; async active-low reset), instantiated at 32×FIFO_DEPTH.

Test Plan:
- Cache model holds addr k = 16'h1000+k; ph_cache_valid pulse high 10 cycles then low; tready=1 → 65 beats: header 32'hA5000000, then beat i = {16'h1000+2i+1, 16'h1000+2i}, tlast only on beat 64; frame_cnt=1, busy low after.
- Same stimulus, tready random 30% duty → identical 65-beat sequence; tdata stable during every stall; FIFO never overflows.
- Second trigger 20 cycles after the first (while busy) → drop_cnt=1, only one packet emitted; a third trigger after IDLE → header 32'hA5000001.
- rst asserted low at beat 30 of a packet → tvalid=0, counters 0 immediately; next trigger yields a full clean packet from header.
- tready=0 for 200 cycles after trigger → header held, no enb beyond credit limit (≤4 reads issued); on release, full correct packet.
- NUM_ENTRIES=2 build → 2 beats: header then {data1, data0} with tlast=1.
